// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - issue/writeback bus of the scoreboarded register file
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 2
);
  localparam int AW = $clog2(NREG);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_ready;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;
  logic                flush;
  logic [AW:0]         pend_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    input  rd_data, rd_ready, pend_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    output rd_data, rd_ready, pend_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-port register file with pending scoreboard and write bypass
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 2
) (
  input  logic          clk,
  input  logic          reset,
  regfile_sb_if.slave   bus
);
  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pend_nxt;
  logic [AW:0]     cnt_nxt;

  // Later write ports override earlier ones, so the highest matching port bypasses.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] d;
      logic            hit;
      ra  = bus.rd_addr[i*AW +: AW];
      d   = regs[ra];
      hit = 1'b0;
      for (int j = 0; j < NWR; j++) begin
        if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] == ra) begin
          hit = 1'b1;
          d   = bus.wr_data[j*XLEN +: XLEN];
        end
      end
      if (ra == '0) begin
        d = '0;
      end
      bus.rd_data[i*XLEN +: XLEN] = d;
      bus.rd_ready[i]             = (ra == '0) || !pending[ra] || hit;
    end
  end

  always_comb begin
    pend_nxt = pending;
    for (int j = 0; j < NWR; j++) begin
      if (bus.wr_en[j]) begin
        pend_nxt[bus.wr_addr[j*AW +: AW]] = 1'b0;
      end
    end
    if (bus.rsv_en) begin
      pend_nxt[bus.rsv_addr] = 1'b1;
    end
    if (bus.flush) begin
      pend_nxt = '0;
    end
    pend_nxt[0] = 1'b0;
    cnt_nxt = '0;
    for (int k = 0; k < NREG; k++) begin
      cnt_nxt = cnt_nxt + (AW+1)'(pend_nxt[k]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NREG; k++) begin
        regs[k] <= '0;
      end
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] != '0) begin
          regs[bus.wr_addr[j*AW +: AW]] <= bus.wr_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending      <= '0;
      bus.pend_cnt <= '0;
    end else begin
      pending      <= pend_nxt;
      bus.pend_cnt <= cnt_nxt;
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed self-checking bench for regfile_sb
module tb_regfile_sb;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int AW   = 5;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  regfile_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus ();

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.wr_en    = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rsv_en   = 1'b0;
    bus.rsv_addr = '0;
    bus.flush    = 1'b0;
  endtask

  task automatic set_rd(input int p, input int a);
    bus.rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input int p, input int a, input logic [XLEN-1:0] d);
    bus.wr_en[p]              = 1'b1;
    bus.wr_addr[p*AW +: AW]   = AW'(a);
    bus.wr_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic reserve(input int a);
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = AW'(a);
  endtask

  function automatic logic [XLEN-1:0] rdat(input int p);
    return bus.rd_data[p*XLEN +: XLEN];
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1ns later, well before the rising edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    bus.rd_addr = '0;
    idle();

    @(negedge clk);
    for (int c = 0; c < 6; c++) begin
      bus.wr_en    = NWR'($urandom_range(3, 1));
      bus.wr_addr  = (NWR*AW)'($urandom);
      bus.wr_data  = {$urandom, $urandom};
      bus.rsv_en   = 1'b1;
      bus.rsv_addr = AW'($urandom_range(31, 1));
      step();
    end
    #1;
    check("pend_cnt_in_reset", bus.pend_cnt, 0);
    idle();
    reset = 1'b1;
    #1;
    for (int a = 0; a < NREG; a += 2) begin
      set_rd(0, a);
      set_rd(1, a + 1);
      #1;
      check("reset_rd_data0", rdat(0), 0);
      check("reset_rd_data1", rdat(1), 0);
      check("reset_rd_ready", bus.rd_ready, 2'b11);
    end
    check("reset_pend_cnt", bus.pend_cnt, 0);

    step();
    set_wr(0, 5, 32'hDEADBEEF);
    set_rd(0, 5);
    set_rd(1, 6);
    #1;
    check("bypass_x5", rdat(0), 32'hDEADBEEF);
    check("bypass_other_port", rdat(1), 0);
    step();
    idle();
    #1;
    check("stored_x5", rdat(0), 32'hDEADBEEF);

    step();
    set_wr(0, 0, 32'h1234);
    reserve(0);
    set_rd(0, 0);
    set_rd(1, 0);
    #1;
    check("x0_bypass_blocked", rdat(0), 0);
    check("x0_ready", bus.rd_ready, 2'b11);
    step();
    idle();
    #1;
    check("x0_stored", rdat(1), 0);
    check("x0_pend_cnt", bus.pend_cnt, 0);

    step();
    reserve(7);
    set_rd(0, 7);
    #1;
    check("rsv_same_cycle_ready", bus.rd_ready[0], 1'b1);
    step();
    idle();
    #1;
    check("x7_pending", bus.rd_ready[0], 1'b0);
    check("x7_pend_cnt", bus.pend_cnt, 1);
    set_wr(1, 7, 32'h55);
    #1;
    check("x7_wb_ready", bus.rd_ready[0], 1'b1);
    check("x7_wb_data", rdat(0), 32'h55);
    step();
    idle();
    #1;
    check("x7_released_cnt", bus.pend_cnt, 0);
    check("x7_released_ready", bus.rd_ready[0], 1'b1);

    set_wr(0, 3, 32'h11);
    set_wr(1, 3, 32'h22);
    set_rd(0, 3);
    #1;
    check("collide_bypass", rdat(0), 32'h22);
    step();
    idle();
    #1;
    check("collide_stored", rdat(0), 32'h22);
    reserve(3);
    set_wr(0, 3, 32'h33);
    #1;
    check("rsv_wr_same_ready", bus.rd_ready[0], 1'b1);
    step();
    idle();
    #1;
    check("rsv_wins_ready", bus.rd_ready[0], 1'b0);
    check("rsv_wins_cnt", bus.pend_cnt, 1);
    check("rsv_wins_data", rdat(0), 32'h33);

    for (int a = 1; a < NREG; a++) begin
      reserve(a);
      step();
    end
    idle();
    set_rd(1, 31);
    #1;
    check("full_pend_cnt", bus.pend_cnt, 31);
    check("full_x31_ready", bus.rd_ready[1], 1'b0);

    bus.flush = 1'b1;
    reserve(9);
    step();
    idle();
    set_rd(0, 9);
    set_rd(1, 5);
    #1;
    check("flush_cnt", bus.pend_cnt, 0);
    check("flush_ready", bus.rd_ready, 2'b11);
    check("flush_keep_x5", rdat(1), 32'hDEADBEEF);
    set_rd(0, 3);
    #1;
    check("flush_keep_x3", rdat(0), 32'h33);

    reserve(4);
    set_wr(0, 6, 32'hAA);
    step();
    idle();
    set_rd(0, 6);
    set_rd(1, 4);
    #1;
    check("pre_reset_x6", rdat(0), 32'hAA);
    check("pre_reset_cnt", bus.pend_cnt, 1);
    #1;
    reset = 1'b0;
    #1;
    check("async_reset_x6", rdat(0), 0);
    check("async_reset_cnt", bus.pend_cnt, 0);
    check("async_reset_ready", bus.rd_ready, 2'b11);
    step();
    reset = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised multi-port integer register file with a per-register pending (scoreboard) bit and same-cycle write-to-read bypass.
- Sits between issue and writeback in the core pipeline.
- Issue reserves a destination register. Writeback ports write data and release the reservation.
- Read ports return operand data plus a ready flag, so issue can stall on unresolved operands.
- Register 0 is hardwired to zero.

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of registers (power of two, >= 2)
AW, $clog2(NREG), address width (derived; not overridden)
NRD, 2, number of read ports
NWR, 2, number of write (writeback) ports

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
rd_addr  in  NRD*AW  read addresses; port i = bits [i*AW +: AW]
rd_data  out  NRD*XLEN  read data per port
rd_ready  out  NRD  1 = operand valid this cycle
wr_en  in  NWR  write enable per port
wr_addr  in  NWR*AW  write address per port
wr_data  in  NWR*XLEN  write data per port
rsv_en  in  1  reserve request from issue
rsv_addr  in  AW  register to mark pending
flush  in  1  clear all pending bits (pipeline flush)
pend_cnt  out  AW+1  registered count of pending registers

Behaviour:
- Reset (reset==0, asynchronous): all registers = 0, all pending bits = 0, pend_cnt = 0. No state changes while reset is held low.
- Reads are combinational.
  - If any wr_en[j] with wr_addr[j]==rd_addr[i] and rd_addr[i]!=0: rd_data[i] = wr_data of the highest-index matching port (bypass).
  - Otherwise: rd_data[i] = stored value.
- rd_ready[i] = 1 when any of the following holds:
  - rd_addr[i]==0;
  - pending[rd_addr[i]]==0;
  - a same-cycle write matches rd_addr[i].
- A same-cycle rsv_en does not affect this cycle's rd_data or rd_ready.
- Writes on the rising edge:
  - Each enabled port writes wr_data to wr_addr.
  - Two ports with the same address in one cycle: the highest-index port wins.
  - Writes to address 0 are ignored.
  - Data is visible in storage the next cycle; the same cycle sees it via bypass.
- Pending update on the rising edge, applied in this order:
  1. Any enabled write clears pending[wr_addr].
  2. rsv_en sets pending[rsv_addr]. Reserve wins over a same-cycle write to the same address (new producer).
  3. flush clears every pending bit. flush overrides 1 and 2, including a same-cycle rsv_en.
  4. rsv_addr==0 is ignored; pending[0] is constant 0.
- Register data is unaffected by flush.
- A write to a non-pending register is legal: data updates, pending stays 0.
- pend_cnt is a registered popcount of the next pending vector.
  - Updated each edge; maximum NREG-1.
  - Never wraps; must equal the popcount exactly every cycle.
- No backpressure: reserve and write are accepted unconditionally. Issue must check rd_ready before reserving.

Test Plan:
- Reset: hold reset=0 with random wr_en/rsv_en, then release → every rd_data=0, rd_ready=all 1, pend_cnt=0.
- Write then read:
  - write x5=0xDEADBEEF on port 0;
  - same cycle, rd_addr0=5 → rd_data0=0xDEADBEEF (bypass);
  - next cycle, no write → still 0xDEADBEEF.
- Register 0: write x0=0x1234 and rsv x0 → reads of x0 return 0, rd_ready=1, pend_cnt unchanged.
- Scoreboard:
  - rsv x7 → next cycle rd_ready for x7=0, pend_cnt=1;
  - write x7=0x55 on port 1 → same cycle rd_ready=1 and rd_data=0x55;
  - next cycle pend_cnt=0.
- Collisions:
  - ports 0 and 1 both write x3 (0x11, 0x22) → x3=0x22;
  - same-cycle rsv x3 plus write x3 → x3 pending afterwards, pend_cnt=1.
- Flush and reset:
  - reserve x1..x31 over 31 cycles → pend_cnt=31;
  - flush with rsv x9 → pend_cnt=0, all ready, data retained;
  - assert reset mid-sequence → immediate clear of all state.
